telemetry_framer: RTL and testbench
===================================

# telemetry_framer

Collects the speed-loop telemetry (measured left/right RPM, applied left/right PWM duty) at a fixed sample rate. Serialises each sample into a 10-byte checksummed frame and feeds it byte-by-byte to the existing 8-bit `uart_tx` through its start/done handshake. Sits between the tachometer/PID/duty registers and `uart_tx`, and drives `uart_tx`'s `start`/`din` ports from `top`. Transmission is gated by the UART enable switch and the host's active-low DTR.

## Interface
- `SAMPLE_DIV`, 1_250_000: clock cycles between sample ticks; must be ≥ 2. Default gives 100 Hz at 125 MHz.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `uart_en` in 1: raw switch input; 1 = telemetry enabled.
- `dtr` in 1: raw host DTR pin; 0 = PC ready.
- `rpm_l` in 9: measured left RPM.
- `rpm_r` in 9: measured right RPM.
- `duty_l` in 16: current left duty register.
- `duty_r` in 16: current right duty register.
- `tx_start` out 1: one-cycle pulse to `uart_tx.start`.
- `tx_data` out 8: byte to `uart_tx.din`.
- `tx_done` in 1: one-cycle pulse from `uart_tx.done`.
- `frame_busy` out 1: high from snapshot until the last byte's `tx_done`.
- `drop_cnt` out 8: saturating count of sample ticks lost because a frame was in flight.

## Operation
- `uart_en` and `dtr` each pass a 2-flop synchronizer.
  - Reset values: `en_s`=0, `dtr_s`=1.
  - `ok = en_s & ~dtr_s`.
- Period counter `pcnt` (width `$clog2(SAMPLE_DIV)`) runs continuously, independent of `ok`.
  - `tick` is high in the cycle where `pcnt == SAMPLE_DIV-1`.
  - In that cycle `pcnt` wraps to 0.
- Frame, big-endian, 10 bytes:
  - 0: 0xA5
  - 1–2: {7'b0, rpm_l[8]}, rpm_l[7:0]
  - 3–4: {7'b0, rpm_r[8]}, rpm_r[7:0]
  - 5–6: duty_l[15:8], duty_l[7:0]
  - 7–8: duty_r[15:8], duty_r[7:0]
  - 9: XOR of bytes 1–8. The sync byte is excluded.
- FSM states: IDLE, SEND, WAIT.
  - **IDLE**: on `tick & ok`, capture all four inputs into a snapshot register, compute the checksum from the snapshot, set `idx`=0, go to SEND.
  - **SEND**: assert `tx_start` for exactly this one cycle, drive `tx_data` = byte[`idx`], go to WAIT.
  - **WAIT**: hold `tx_data` stable until `tx_done` arrives.
    - If `tx_done` and `idx`==9: go to IDLE.
    - If `tx_done` and `idx`<9: increment `idx`, go to SEND.
- `frame_busy` = (state != IDLE).
- Boundary behaviour:
  - **Tick while busy**: ignored for framing. `drop_cnt` increments, saturating at 255. Ticks while `!ok` and IDLE are neither sent nor counted.
  - **`ok` falls mid-frame**: the frame completes. Frames are never truncated; gating applies only at frame start.
  - **Last `tx_done` coincides with a tick**: the tick counts as dropped. The next frame starts on the following tick.
  - **`tx_done` outside WAIT**: ignored.
  - **Inputs changing mid-frame**: no effect. Only the snapshot is transmitted.
  - **`reset_n` low mid-frame**: all state is cleared asynchronously and the partial frame is abandoned. `uart_tx` shares reset.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=0x00, `frame_busy`=0, `drop_cnt`=0.
  - `pcnt`=0, state IDLE, snapshot 0.
- First tick occurs `SAMPLE_DIV-1` cycles after reset release.
- `uart_en`/`dtr` to `ok` latency: 2 cycles.
- Tick cycle T (IDLE, ok): snapshot at edge T. `tx_start`=1 and `tx_data`=0xA5 registered in cycle T+1. `frame_busy`=1 from T+1.
- `tx_done` in cycle D: next `tx_start` in D+1, so 1 idle cycle between bytes.
- After the last `tx_done` in cycle D: `frame_busy`=0 in D+1.
- All outputs are registered.

## Structure
- Package `telemetry_pkg`:
  - `SYNC_BYTE` = 8'hA5, `FRAME_LEN` = 10.
  - `state_t` enum {IDLE, SEND, WAIT}.
  - `frame_t` as a packed struct of the snapshot fields.
- Sub-module `sync_2ff`, with a reset-value parameter, instantiated twice (en, dtr).
- Byte mux and checksum are combinational from the snapshot, inside `telemetry_framer`.

## Test plan
Bench uses `SAMPLE_DIV`=64 and a `uart_tx` model returning `tx_done` 20 cycles after each `tx_start`.
- **Nominal frame**: `uart_en`=1, `dtr`=0, rpm_l=300, rpm_r=100, duty_l=0x1234, duty_r=0xFFFF → bytes A5 01 2C 00 64 12 34 FF FF 6F, exactly 10 `tx_start` pulses, `frame_busy` low after the 10th done.
- **Gating**: `dtr`=1 for 5 ticks → no `tx_start`, `drop_cnt`=0. `dtr`→0 → frame starts on the first tick ≥ 2 cycles later.
- **Snapshot stability**: change rpm_l every cycle mid-frame → transmitted bytes equal the values at the tick; checksum consistent.
- **Overrun**: model `tx_done` delay 200 cycles (frame spans ~31 ticks) → `drop_cnt` increments once per tick while busy. Run long enough → `drop_cnt` holds at 255.
- **Disable and reset mid-frame**: `uart_en`→0 after byte 3 → all 10 bytes still sent, no further frames. Separately, `reset_n` low at byte 5 → `tx_start`/`tx_data`/`frame_busy`/`drop_cnt` go to 0 immediately; after release, the first frame starts with 0xA5.

Source files
------------

// File: rtl/telemetry_pkg.sv
// Shared constants and types for the speed-loop telemetry framer.
package telemetry_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned FRAME_LEN = 10;
  localparam int unsigned IDX_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [8:0]  rpm_l;
    logic [8:0]  rpm_r;
    logic [15:0] duty_l;
    logic [15:0] duty_r;
  } frame_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single raw input; RST_VAL sets the reset level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/telemetry_framer.sv
// Samples speed-loop telemetry at a fixed rate and streams 10-byte
// checksummed frames to uart_tx through its start/done handshake.
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 1_250_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_en,
  input  logic        dtr,
  input  logic [8:0]  rpm_l,
  input  logic [8:0]  rpm_r,
  input  logic [15:0] duty_l,
  input  logic [15:0] duty_r,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        frame_busy,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned      PCNT_W   = $clog2(SAMPLE_DIV);
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(SAMPLE_DIV - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic              en_s;
  logic              dtr_s;
  logic              ok_c;
  logic [PCNT_W-1:0] pcnt;
  logic              tick_c;

  state_t            state, state_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [IDX_W-1:0]  nxt_idx_c;
  frame_t            snap, snap_d;
  logic [7:0]        csum_c;
  logic [7:0]        byte_c;

  logic              tx_start_d;
  logic [7:0]        tx_data_d;
  logic              frame_busy_d;
  logic [7:0]        drop_cnt_d;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_en (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (uart_en),
    .q       (en_s)
  );

  sync_2ff #(.RST_VAL(1'b1)) u_sync_dtr (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (dtr),
    .q       (dtr_s)
  );

  assign ok_c   = en_s & ~dtr_s;
  assign tick_c = (pcnt == PCNT_MAX);

  // Free-running sample period counter, independent of gating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    pcnt <= '0;
    else if (tick_c) pcnt <= '0;
    else             pcnt <= pcnt + PCNT_W'(1);
  end

  assign csum_c = {7'b0, snap.rpm_l[8]} ^ snap.rpm_l[7:0] ^
                  {7'b0, snap.rpm_r[8]} ^ snap.rpm_r[7:0] ^
                  snap.duty_l[15:8] ^ snap.duty_l[7:0] ^
                  snap.duty_r[15:8] ^ snap.duty_r[7:0];

  // Byte 0 is loaded directly at frame start, so the mux only serves idx+1.
  assign nxt_idx_c = idx + IDX_W'(1);

  always_comb begin
    byte_c = SYNC_BYTE;
    case (nxt_idx_c)
      4'd1:    byte_c = {7'b0, snap.rpm_l[8]};
      4'd2:    byte_c = snap.rpm_l[7:0];
      4'd3:    byte_c = {7'b0, snap.rpm_r[8]};
      4'd4:    byte_c = snap.rpm_r[7:0];
      4'd5:    byte_c = snap.duty_l[15:8];
      4'd6:    byte_c = snap.duty_l[7:0];
      4'd7:    byte_c = snap.duty_r[15:8];
      4'd8:    byte_c = snap.duty_r[7:0];
      4'd9:    byte_c = csum_c;
      default: byte_c = SYNC_BYTE;
    endcase
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    snap_d     = snap;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    drop_cnt_d = drop_cnt;

    case (state)
      IDLE: begin
        if (tick_c && ok_c) begin
          snap_d     = '{rpm_l: rpm_l, rpm_r: rpm_r, duty_l: duty_l, duty_r: duty_r};
          idx_d      = '0;
          tx_start_d = 1'b1;
          tx_data_d  = SYNC_BYTE;
          state_d    = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (idx == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d      = nxt_idx_c;
            tx_start_d = 1'b1;
            tx_data_d  = byte_c;
            state_d    = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (tick_c && (state != IDLE) && (drop_cnt != 8'hFF))
      drop_cnt_d = drop_cnt + 8'd1;

    frame_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      snap       <= '0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      frame_busy <= 1'b0;
      drop_cnt   <= 8'h00;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      snap       <= snap_d;
      tx_start   <= tx_start_d;
      tx_data    <= tx_data_d;
      frame_busy <= frame_busy_d;
      drop_cnt   <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer with a fixed-latency uart_tx model.
module tb_telemetry_framer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_en = 1'b0;
  logic        dtr = 1'b1;
  logic [8:0]  rpm_l = '0;
  logic [8:0]  rpm_r = '0;
  logic [15:0] duty_l = '0;
  logic [15:0] duty_r = '0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        frame_busy;
  logic [7:0]  drop_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc;
  int          done_dly = 20;
  int          dcnt;
  int          dbl_start = 0;
  logic        prev_start;
  logic [7:0]  caps[$];
  int          scyc[$];

  telemetry_framer #(.SAMPLE_DIV(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .uart_en    (uart_en),
    .dtr        (dtr),
    .rpm_l      (rpm_l),
    .rpm_r      (rpm_r),
    .duty_l     (duty_l),
    .duty_r     (duty_r),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .frame_busy (frame_busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Cycle k after reset release reads cyc == k.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // uart_tx model: tx_start in cycle S -> tx_done in cycle S+done_dly.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dcnt    <= 0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_start) dcnt <= done_dly - 1;
      else if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) tx_done <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    prev_start <= tx_start;
    if (reset_n && tx_start) begin
      caps.push_back(tx_data);
      scyc.push_back(cyc);
      if (prev_start) dbl_start <= dbl_start + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    caps.delete();
    scyc.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_caps(input int n, input int budget, input string tag);
    int b = 0;
    while (caps.size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    chk(tag, 32'(caps.size() >= n), 32'd1);
  endtask

  task automatic set_nominal();
    rpm_l  = 9'd300;
    rpm_r  = 9'd100;
    duty_l = 16'h1234;
    duty_r = 16'hFFFF;
  endtask

  logic [7:0] exp_nom [10] = '{8'hA5, 8'h01, 8'h2C, 8'h00, 8'h64,
                                8'h12, 8'h34, 8'hFF, 8'hFF, 8'h6F};
  logic [7:0] exp_snp [10] = '{8'hA5, 8'h01, 8'hA5, 8'h00, 8'hF0,
                                8'hBE, 8'hEF, 8'h01, 8'h02, 8'h06};

  initial begin
    int b;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_busy", 32'(frame_busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // Nominal frame
    done_dly = 20;
    uart_en = 1'b1;
    dtr = 1'b0;
    set_nominal();
    do_reset();
    wait_caps(10, 400, "nom_caps");
    b = 0;
    while (!tx_done && b < 50) begin
      @(negedge clk);
      b++;
    end
    chk("nom_last_done", 32'(tx_done), 32'd1);
    chk("nom_busy_at_done", 32'(frame_busy), 32'd1);
    @(negedge clk);
    chk("nom_busy_after", 32'(frame_busy), 32'd0);
    chk("nom_drop", 32'(drop_cnt), 32'd3);
    wait_cyc(300);
    chk("nom_count", 32'(caps.size()), 32'd10);
    if (caps.size() >= 10) begin
      for (int i = 0; i < 10; i++) chk($sformatf("nom_byte%0d", i), 32'(caps[i]), 32'(exp_nom[i]));
      chk("nom_first_cyc", 32'(scyc[0]), 32'd64);
      chk("nom_gap", 32'(scyc[1] - scyc[0]), 32'd21);
      chk("nom_last_cyc", 32'(scyc[9]), 32'd253);
    end

    // Gating by DTR, then release one cycle too late for the next tick
    dtr = 1'b1;
    do_reset();
    wait_cyc(382);
    chk("gate_no_start", 32'(caps.size()), 32'd0);
    chk("gate_drop", 32'(drop_cnt), 32'd0);
    dtr = 1'b0;
    wait_caps(1, 200, "gate_caps");
    if (caps.size() >= 1) begin
      chk("gate_first_cyc", 32'(scyc[0]), 32'd448);
      chk("gate_sync", 32'(caps[0]), 32'hA5);
    end

    // Snapshot stability
    rpm_l = 9'h1A5;
    rpm_r = 9'h0F0;
    duty_l = 16'hBEEF;
    duty_r = 16'h0102;
    do_reset();
    wait_cyc(64);
    repeat (220) begin
      rpm_l = 9'($urandom);
      duty_l = 16'($urandom);
      @(negedge clk);
    end
    wait_caps(10, 100, "snap_caps");
    if (caps.size() >= 10)
      for (int i = 0; i < 10; i++) chk($sformatf("snap_byte%0d", i), 32'(caps[i]), 32'(exp_snp[i]));

    // Overrun and drop counter saturation
    set_nominal();
    done_dly = 200;
    do_reset();
    wait_cyc(200);
    chk("ovr_drop_200", 32'(drop_cnt), 32'd2);
    wait_cyc(2074);
    chk("ovr_busy_end", 32'(frame_busy), 32'd0);
    chk("ovr_drop_frame", 32'(drop_cnt), 32'd31);
    chk("ovr_count", 32'(caps.size()), 32'd10);
    wait_cyc(18000);
    chk("ovr_sat_a", 32'(drop_cnt), 32'd255);
    wait_cyc(19000);
    chk("ovr_sat_b", 32'(drop_cnt), 32'd255);

    // Disable mid-frame: frame completes, nothing further
    done_dly = 20;
    uart_en = 1'b1;
    do_reset();
    wait_caps(4, 200, "dis_caps");
    uart_en = 1'b0;
    wait_cyc(700);
    chk("dis_count", 32'(caps.size()), 32'd10);
    chk("dis_busy", 32'(frame_busy), 32'd0);
    if (caps.size() >= 10) chk("dis_csum", 32'(caps[9]), 32'h6F);

    // Reset during byte 5's start cycle
    uart_en = 1'b1;
    do_reset();
    wait_cyc(169);
    chk("mid_pre_start", 32'(tx_start), 32'd1);
    chk("mid_pre_data", 32'(tx_data), 32'h12);
    chk("mid_pre_drop", 32'(drop_cnt), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_start", 32'(tx_start), 32'd0);
    chk("mid_rst_data", 32'(tx_data), 32'h00);
    chk("mid_rst_busy", 32'(frame_busy), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    caps.delete();
    scyc.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_caps(1, 100, "mid_caps");
    if (caps.size() >= 1) begin
      chk("mid_sync", 32'(caps[0]), 32'hA5);
      chk("mid_first_cyc", 32'(scyc[0]), 32'd64);
    end

    chk("start_one_cycle", 32'(dbl_start), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
